edge_level_rebuilder: RTL and testbench

Reconstructs a clean level signal from single-cycle rise/fall event pulses, such as those produced by the upstream edge detector. It is the inverse stage of edge detection. Every output transition is held for a programmable minimum number of cycles. Events that are illegal, redundant or arrive too early are flagged, queued (optional) or dropped and counted. The block sits downstream of the edge-detect path and drives level-sensitive consumers such as GPIO replay and test waveforms.

---
 rtl/edge_rebuild_pkg.sv | 18 +
 rtl/edge_level_rebuilder_hold_timer.sv | 38 +++
 rtl/edge_level_rebuilder.sv | 121 ++++++++++++
 tb/tb_edge_level_rebuilder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/edge_rebuild_pkg.sv
// Shared definitions for the edge_level_rebuilder slice.
//   rebuild_state_e : FSM state encoding; bit 0 is the level of the state and
//                     bit 1 marks a hold window.
//   hold_timer_w()  : width of the hold down-counter for a given MIN_HOLD.
package edge_rebuild_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'b00,
    IDLE_HI = 2'b01,
    HOLD_LO = 2'b10,
    HOLD_HI = 2'b11
  } rebuild_state_e;

  function automatic int hold_timer_w(input int min_hold);
    return (min_hold < 1) ? 1 : $clog2(min_hold + 1);
  endfunction

endpackage

// File: rtl/edge_level_rebuilder_hold_timer.sv
// hold_timer: loadable down-counter that times the hold window after a
// level_out transition.
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   load   : restart the window (a transition happens at this edge)
//   expire : high when the count has run out; the owner acts on it at the
//            next edge, which is exactly MIN_HOLD edges after the load
module hold_timer
  import edge_rebuild_pkg::*;
#(
  parameter int MIN_HOLD = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);

  localparam int TW = hold_timer_w(MIN_HOLD);
  // Loading MIN_HOLD-1 makes expire visible after edge k+MIN_HOLD-1 so the
  // follow-up transition can be taken at edge k+MIN_HOLD.
  localparam logic [TW-1:0] LOAD_VAL = TW'(MIN_HOLD - 1);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - TW'(1);
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/edge_level_rebuilder.sv
// edge_level_rebuilder: rebuilds a level from single-cycle rise/fall pulses,
// holding every transition for at least MIN_HOLD cycles.
//   clk           : clock, rising edge
//   rst           : asynchronous active-high reset
//   rise_pulse    : request 0->1
//   fall_pulse    : request 1->0
//   level_out     : reconstructed level (registered)
//   busy          : hold window active, events are not applied
//   err_both      : one cycle, both pulses were high together
//   err_redundant : one cycle, request equals the effective level
//   edge_cnt      : level_out transitions, wraps
//   drop_cnt      : dropped events, saturates
// Build option EDGE_REBUILD_QUEUE_EN: adds a one-deep pending register so the
// first opposite event during a hold is applied at hold expiry instead of
// being dropped.
module edge_level_rebuilder
  import edge_rebuild_pkg::*;
#(
  parameter int MIN_HOLD = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rise_pulse,
  input  logic             fall_pulse,
  output logic             level_out,
  output logic             busy,
  output logic             err_both,
  output logic             err_redundant,
  output logic [CNT_W-1:0] edge_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  rebuild_state_e state_q, state_d;
  logic level_d;
  logic timer_expire;
  logic in_hold, hold_active;
  logic pend_q, defer;
  logic eff_level, both, one_ev, redundant, opposite;
  logic fire, accept, drop, toggle;

  hold_timer #(.MIN_HOLD(MIN_HOLD)) u_hold_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (toggle),
    .expire (timer_expire)
  );

  assign in_hold     = (state_q == HOLD_LO) || (state_q == HOLD_HI);
  // The expiry cycle already counts as idle for new events.
  assign hold_active = in_hold && !timer_expire;
  assign busy        = hold_active;

  // A pending event always targets the opposite of level_out.
  assign eff_level = level_out ^ pend_q;
  assign both      = rise_pulse && fall_pulse;
  assign one_ev    = rise_pulse ^ fall_pulse;
  assign redundant = one_ev && (rise_pulse == eff_level);
  assign opposite  = one_ev && (rise_pulse != eff_level);

  assign fire   = in_hold && timer_expire && pend_q;
  assign accept = opposite && !hold_active && !pend_q;
  assign drop   = opposite && !accept && !defer;
  assign toggle = accept || fire;

`ifdef EDGE_REBUILD_QUEUE_EN
  assign defer = opposite && hold_active && !pend_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= 1'b0;
    end else if (fire) begin
      pend_q <= 1'b0;
    end else if (defer) begin
      pend_q <= 1'b1;
    end
  end
`else
  assign defer  = 1'b0;
  assign pend_q = 1'b0;
`endif

  always_comb begin
    level_d = level_out;
    state_d = state_q;
    if (in_hold && timer_expire) begin
      state_d = level_out ? IDLE_HI : IDLE_LO;
    end
    if (toggle) begin
      level_d = !level_out;
      if (MIN_HOLD > 1) begin
        state_d = level_d ? HOLD_HI : HOLD_LO;
      end else begin
        state_d = level_d ? IDLE_HI : IDLE_LO;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE_LO;
      level_out     <= 1'b0;
      err_both      <= 1'b0;
      err_redundant <= 1'b0;
      edge_cnt      <= '0;
      drop_cnt      <= '0;
    end else begin
      state_q       <= state_d;
      level_out     <= level_d;
      err_both      <= both;
      err_redundant <= redundant;
      if (toggle) edge_cnt <= edge_cnt + CNT_W'(1);
      if (drop)   drop_cnt <= sat_inc(drop_cnt);
    end
  end

endmodule

// File: tb/tb_edge_level_rebuilder.sv
module tb_edge_level_rebuilder;

`ifdef EDGE_REBUILD_QUEUE_EN
  localparam bit Q = 1'b1;
`else
  localparam bit Q = 1'b0;
`endif

  typedef struct {
    logic r, f;
    logic lvl, busy, eb, er;
    int   ec, dc;
  } row_t;

  logic clk, rst;
  logic rise, fall;
  logic lvl, busy, eb, er;
  logic [7:0] ec, dc;

  logic in_sig, sync_q, prev_q, rise1, fall1, det_rst_n;
  logic lvl1, busy1, eb1, er1;
  logic [7:0] ec1, dc1;

  int n_pass = 0;
  int n_tot  = 0;
  row_t rows[$];
  bit p1, p2, p3;

  edge_level_rebuilder #(.MIN_HOLD(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .rise_pulse(rise), .fall_pulse(fall),
    .level_out(lvl), .busy(busy), .err_both(eb), .err_redundant(er),
    .edge_cnt(ec), .drop_cnt(dc)
  );

  edge_level_rebuilder #(.MIN_HOLD(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .rise_pulse(rise1), .fall_pulse(fall1),
    .level_out(lvl1), .busy(busy1), .err_both(eb1), .err_redundant(er1),
    .edge_cnt(ec1), .drop_cnt(dc1)
  );

  // Upstream edge detector model: synchroniser stage, previous stage and
  // registered pulses, giving a 3-clock in_sig -> level_out path.
  assign det_rst_n = ~rst;
  always_ff @(posedge clk or negedge det_rst_n) begin
    if (!det_rst_n) begin
      sync_q <= 1'b0; prev_q <= 1'b0; rise1 <= 1'b0; fall1 <= 1'b0;
    end else begin
      sync_q <= in_sig;
      prev_q <= sync_q;
      rise1  <= sync_q & ~prev_q;
      fall1  <= ~sync_q & prev_q;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic step(input bit r, input bit f);
    rise = r; fall = f;
    @(posedge clk); #1;
    rise = 1'b0; fall = 1'b0;
  endtask

  task automatic toward(input bit x);
    step(x, !x);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic add(input bit r, input bit f, input bit l, input bit b,
                     input bit e1, input bit e2, input int c, input int d);
    row_t x;
    x.r = r; x.f = f; x.lvl = l; x.busy = b; x.eb = e1; x.er = e2; x.ec = c; x.dc = d;
    rows.push_back(x);
  endtask

  task automatic e2e(input bit v);
    @(posedge clk); #1;
    chk("e2e_level", lvl1, p3);
    chk("e2e_err_both", eb1, 0);
    chk("e2e_err_red", er1, 0);
    chk("e2e_busy", busy1, 0);
    p3 = p2; p2 = p1; p1 = v;
    in_sig = v;
  endtask

  initial begin
    int dq;
    bit L;
    int iters;
    dq = Q ? 0 : 1;
    rst = 1'b1; rise = 1'b0; fall = 1'b0; in_sig = 1'b0;

    // r f  lvl     busy    eb er      ec          dc
    add(1,0, 1,      1,      0, 0,      1,          0);
    add(0,1, 1,      1,      0, 0,      1,          dq);
    add(0,0, 1,      0,      0, 0,      1,          dq);
    add(0,0, Q?0:1,  Q,      0, 0,      Q?2:1,      dq);
    add(0,0, Q?0:1,  Q,      0, 0,      Q?2:1,      dq);
    add(0,0, Q?0:1,  0,      0, 0,      Q?2:1,      dq);
    add(0,0, Q?0:1,  0,      0, 0,      Q?2:1,      dq);
    add(0,1, 0,      Q?0:1,  0, Q,      2,          dq);
    add(0,0, 0,      Q?0:1,  0, 0,      2,          dq);
    add(0,0, 0,      0,      0, 0,      2,          dq);
    add(0,0, 0,      0,      0, 0,      2,          dq);
    add(1,1, 0,      0,      1, 0,      2,          dq);
    add(0,0, 0,      0,      0, 0,      2,          dq);
    add(1,0, 1,      1,      0, 0,      3,          dq);
    add(0,0, 1,      1,      0, 0,      3,          dq);
    add(0,0, 1,      0,      0, 0,      3,          dq);
    add(0,0, 1,      0,      0, 0,      3,          dq);
    add(1,0, 1,      0,      0, 1,      3,          dq);
    add(0,0, 1,      0,      0, 0,      3,          dq);
    add(0,1, 0,      1,      0, 0,      4,          dq);
    add(1,0, 0,      1,      0, 0,      4,          Q?0:2);
    add(0,1, 0,      0,      0, Q?0:1,  4,          Q?1:2);
    add(0,0, Q,      Q,      0, 0,      Q?5:4,      Q?1:2);
    add(0,0, Q,      Q,      0, 0,      Q?5:4,      Q?1:2);
    add(0,0, Q,      0,      0, 0,      Q?5:4,      Q?1:2);
    add(0,0, Q,      0,      0, 0,      Q?5:4,      Q?1:2);

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_level", lvl, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_both", eb, 0);
    chk("rst_err_red", er, 0);
    chk("rst_edge_cnt", ec, 0);
    chk("rst_drop_cnt", dc, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) step(0, 0);

    foreach (rows[i]) begin
      step(rows[i].r, rows[i].f);
      chk($sformatf("row%0d_level", i), lvl, rows[i].lvl);
      chk($sformatf("row%0d_busy", i), busy, rows[i].busy);
      chk($sformatf("row%0d_err_both", i), eb, rows[i].eb);
      chk($sformatf("row%0d_err_red", i), er, rows[i].er);
      chk($sformatf("row%0d_edge_cnt", i), ec, rows[i].ec);
      chk($sformatf("row%0d_drop_cnt", i), dc, rows[i].dc);
    end

    // Drop-counter saturation: 260 dropped events in total
    do_reset();
    L = 1'b0;
    iters = Q ? 260 : 130;
    for (int it = 0; it < iters; it++) begin
      toward(!L);
      toward(L);
      toward(Q ? !L : L);
      repeat (4) step(0, 0);
      if (it == 0) chk("sat_first_iter_drop", dc, Q ? 1 : 2);
      if (!Q) L = !L;
    end
    chk("sat_drop_cnt", dc, 255);
    chk("sat_edge_cnt", ec, Q ? 8 : 130);

    // Mid-hold asynchronous reset
    do_reset();
    step(1, 0);
    step(0, 1);
    #2 rst = 1'b1;
    #1;
    chk("mrst_level", lvl, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_edge_cnt", ec, 0);
    chk("mrst_drop_cnt", dc, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(1, 0);
    chk("mrst_next_level", lvl, 1);
    chk("mrst_next_busy", busy, 1);
    chk("mrst_next_edge_cnt", ec, 1);
    repeat (4) step(0, 0);
    chk("mrst_no_pending_level", lvl, 1);
    chk("mrst_no_pending_edge_cnt", ec, 1);
    chk("mrst_no_pending_drop", dc, 0);

    // MIN_HOLD=1 through the edge detector: edge_cnt wrap, then random
    do_reset();
    p1 = 0; p2 = 0; p3 = 0;
    for (int i = 0; i < 258; i++) e2e((i % 2) == 0);
    repeat (3) e2e(p1);
    chk("wrap_edge_cnt", ec1, 2);
    chk("wrap_drop_cnt", dc1, 0);
    for (int i = 0; i < 300; i++) e2e(bit'($urandom_range(0, 1)));
    repeat (3) e2e(p1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
